// File: rtl/alu_result_uart_tx_if.sv
// Result/handshake bundle between the ALU return path and its UART transmitter.
// master: the side that presents a result and requests a send.
// slave : the transmitter itself.
interface alu_result_uart_tx_if #(
    parameter int NB_DATA = 8
);
    logic signed [NB_DATA-1:0] i_result;
    logic                      i_send;
    logic                      o_tx;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output i_result,
        output i_send,
        input  o_tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_result,
        input  i_send,
        output o_tx,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/alu_result_uart_tx.sv
// ALU result return path: captures the signed ALU result on a send request
// and serialises it LSB first on a UART TX line (8N1 by default).
// Optional even parity bit (8E1) when ALU_RESULT_TX_PARITY_EN is defined.
// All outputs are registered; reset is asynchronous and active high.
module alu_result_uart_tx #(
    parameter int NB_DATA      = 8,
    parameter int CLKS_PER_BIT = 10417
) (
    input logic                 i_clock,
    input logic                 i_reset,
    alu_result_uart_tx_if.slave bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ALU_RESULT_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state_q,  state_d;
    logic [BAUD_W-1:0]   baud_q,   baud_d;
    logic [BIT_W-1:0]    bit_q,    bit_d;
    logic [NB_DATA-1:0]  shift_q,  shift_d;
    logic                tx_q,     tx_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic; tx/busy/done are computed one edge ahead so the
    // registered line changes on the same edge as the state transition.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.i_send) begin
                    state_d  = START;
                    shift_d  = bus.i_result;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    baud_d   = '0;
                    bit_d    = '0;
`ifdef ALU_RESULT_TX_PARITY_EN
                    parity_d = ^bus.i_result;
`endif
                end
            end

            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef ALU_RESULT_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Next bit is taken from the already-shifted value.
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

`ifdef ALU_RESULT_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif

            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.o_tx   = tx_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: directed table of frames, hand-written reset
// sequences and random frames, checked against a bit-list frame model.
module tb_alu_result_uart_tx;

    localparam int NB  = 8;
    localparam int CPB = 16;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS = NB + 2 + (PAR_EN ? 1 : 0);
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_result_uart_tx_if #(.NB_DATA(NB)) bus ();

    alu_result_uart_tx #(
        .NB_DATA      (NB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [7:0] data;
        bit         hold;
        int         inj_cycle;
        logic [7:0] inj_data;
        bit         exp_par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame: expected line = start(0), data LSB first, [parity], stop(1),
    // each bit CPB cycles; k counts negedges after the accept edge.
    task automatic run_frame(input logic [7:0] data, input bit exp_par, input bit chain,
                             input bit hold, input int inj_cycle, input logic [7:0] inj_data);
        bit exp_bits[NBITS];
        int done_at  = -1;
        int busy_cnt = 0;
        int done_cnt = 0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < NB; i++) exp_bits[1 + i] = data[i];
        if (PAR_EN) exp_bits[NB + 1] = exp_par;
        exp_bits[NBITS - 1] = 1'b1;

        if (!chain) @(negedge clk);
        bus.i_result = data;
        bus.i_send   = 1'b1;
        @(negedge clk);
        if (!hold) bus.i_send = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.o_busy) busy_cnt++;
            if (bus.o_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 0) check($sformatf("start_edge_%02h", data), 32'(bus.o_tx), 32'd0);
            if (k < FRAME && (k % CPB) == CPB / 2)
                check($sformatf("bit%0d_of_%02h", k / CPB, data), 32'(bus.o_tx), 32'(exp_bits[k / CPB]));
            if (k == inj_cycle) begin
                bus.i_result = inj_data;
                bus.i_send   = 1'b1;
            end
            if (k == inj_cycle + 1) bus.i_send = hold;
        end
        check($sformatf("done_at_%02h", data), done_at, FRAME);
        check($sformatf("done_cnt_%02h", data), done_cnt, 1);
        check($sformatf("busy_cycles_%02h", data), busy_cnt, FRAME);
        check($sformatf("tx_idle_at_done_%02h", data), 32'(bus.o_tx), 32'd1);
    endtask

    vec_t tbl[6];

    initial begin
        int lows  = 0;
        int dones = 0;
        bit prev_hold = 1'b0;

        tbl[0] = '{data: 8'h55, hold: 1'b0, inj_cycle: -1, inj_data: 8'h00, exp_par: 1'b0};
        tbl[1] = '{data: 8'hF8, hold: 1'b0, inj_cycle: -1, inj_data: 8'h00, exp_par: 1'b1};
        tbl[2] = '{data: 8'h07, hold: 1'b1, inj_cycle: -1, inj_data: 8'h00, exp_par: 1'b1};
        tbl[3] = '{data: 8'h07, hold: 1'b1, inj_cycle: -1, inj_data: 8'h00, exp_par: 1'b1};
        tbl[4] = '{data: 8'h5A, hold: 1'b0, inj_cycle: -1, inj_data: 8'h00, exp_par: 1'b0};
        tbl[5] = '{data: 8'hA3, hold: 1'b0, inj_cycle: 40, inj_data: 8'h00, exp_par: 1'b0};

        bus.i_result = '0;
        bus.i_send   = 1'b0;
        rst          = 1'b1;
        #1;
        check("reset_tx",   32'(bus.o_tx),   32'd1);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        check("reset_done", 32'(bus.o_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].data, tbl[i].exp_par, prev_hold, tbl[i].hold,
                      tbl[i].inj_cycle, tbl[i].inj_data);
            prev_hold = tbl[i].hold;
        end

        // Line must stay idle after a frame with an ignored mid-frame request.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.o_tx) lows++;
            if (bus.o_done) dones++;
        end
        check("idle_after_ignore_tx_low", lows, 0);
        check("idle_after_ignore_done", dones, 0);

        // Reset during data bit 3 of 0xFF.
        @(negedge clk);
        bus.i_result = 8'hFF;
        bus.i_send   = 1'b1;
        @(negedge clk);
        bus.i_send = 1'b0;
        repeat (4 * CPB + 4) @(negedge clk);
        check("busy_before_reset", 32'(bus.o_busy), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_tx",   32'(bus.o_tx),   32'd1);
        check("midreset_busy", 32'(bus.o_busy), 32'd0);
        check("midreset_done", 32'(bus.o_done), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        rst = 1'b0;
        repeat (CPB) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        check("no_done_after_abort", dones, 0);
        run_frame(8'h0F, 1'b0, 1'b0, 1'b0, -1, 8'h00);

        // Random frames with a random ignored request during the frame.
        for (int r = 0; r < 8; r++) begin
            logic [7:0] d;
            logic [7:0] dj;
            int         inj;
            d   = 8'($urandom);
            dj  = 8'($urandom);
            inj = int'($urandom_range(1, FRAME - 3));
            run_frame(d, ($countones(d) % 2) == 1, 1'b0, 1'b0, inj, dj);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
